// File: rtl/neuron_pkg.sv
// Shared types for the neuron datapath: FSM state encoding and the accumulator
// width rule used by both this MAC and the downstream ReLU activation stage.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN,
        OUT
    } state_t;

    function automatic int accw(input int data_w, input int ext_w);
        return 2 * data_w + ext_w;
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Input-pair / result handshake bundle between a neuron source and neuron_mac.
interface neuron_mac_if
    import neuron_pkg::*;
#(
    parameter int dataWidth = 16,
    parameter int ACCW      = accw(16, 10)
);

    logic                          start;
    logic signed [2*dataWidth-1:0] bias;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [dataWidth-1:0]   in_data;
    logic signed [dataWidth-1:0]   weight;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACCW-1:0]        out_sum;

    modport master (
        output start, bias, in_valid, in_data, weight, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  start, bias, in_valid, in_data, weight, out_ready,
        output in_ready, out_valid, out_sum
    );

endinterface

// File: rtl/neuron_mul.sv
// Registered full-precision signed multiply; one cycle of latency, valid travels with the product.
module neuron_mul #(
    parameter int dataWidth = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic signed [dataWidth-1:0]   a,
    input  logic signed [dataWidth-1:0]   b,
    output logic signed [2*dataWidth-1:0] prod_p1,
    output logic                          vld_p1
);

    // stage 1: product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= en;
            if (en) begin
                prod_p1 <= a * b;
            end
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: sums numInputs activation*weight products onto a bias.
// Build macro NEURON_MAC_SAT_EN selects a clamping accumulator with sticky sat_flag.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4,
    parameter int IntWidthExtend = 10,
    parameter int numInputs      = 126
) (
    input  logic         clk,
    input  logic         rst_n,
    neuron_mac_if.slave  bus
`ifdef NEURON_MAC_SAT_EN
    ,
    output logic         sat_flag
`endif
);

    localparam int ACCW = accw(dataWidth, IntWidthExtend);
    localparam int PW   = 2 * dataWidth;
    localparam int CW   = $clog2(numInputs + 1);

    if (weightIntWidth < 1 || weightIntWidth > dataWidth) begin : g_fmt_check
        $error("neuron_mac: weightIntWidth must lie within 1..dataWidth");
    end

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_p0;
    logic                   in_ready_c;
    logic                   xfer;
    logic                   load;
    logic signed [PW-1:0]   prod_p1;
    logic                   vld_p1;
    logic signed [ACCW-1:0] acc_p2;
    logic signed [ACCW-1:0] acc_nxt;
    logic signed [ACCW-1:0] out_sum_p3;
    logic                   out_vld_p3;
    logic                   out_hs;

    function automatic logic signed [ACCW-1:0] acc_wrap(
        input logic signed [ACCW-1:0] a,
        input logic signed [PW-1:0]   p
    );
        return a + ACCW'(p);
    endfunction

`ifdef NEURON_MAC_SAT_EN
    logic signed [ACCW:0] sum_w;
    logic                 ovf;

    // One guard bit exposes overflow as disagreement between the top two bits.
    function automatic logic signed [ACCW-1:0] acc_sat(input logic signed [ACCW:0] s);
        logic signed [ACCW-1:0] lim;
        lim = {1'b0, {(ACCW-1){1'b1}}};
        if (s[ACCW] != s[ACCW-1]) begin
            return s[ACCW] ? ~lim : lim;
        end
        return s[ACCW-1:0];
    endfunction

    assign sum_w   = (ACCW+1)'(acc_p2) + (ACCW+1)'(prod_p1);
    assign ovf     = sum_w[ACCW] ^ sum_w[ACCW-1];
    assign acc_nxt = acc_sat(sum_w);
`else
    assign acc_nxt = acc_wrap(acc_p2, prod_p1);
`endif

    assign out_hs = out_vld_p3 && bus.out_ready;
    assign xfer   = bus.in_valid && in_ready_c;
    assign load   = bus.start && ((state_q == IDLE) || (state_q == OUT && out_hs));

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = ACC;
            end
            ACC: begin
                in_ready_c = (cnt_p0 < CW'(numInputs));
                if (bus.in_valid && in_ready_c && cnt_p0 == CW'(numInputs - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (out_hs) state_d = bus.start ? ACC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_p0  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_p0 <= '0;
            end else if (xfer) begin
                cnt_p0 <= cnt_p0 + 1'b1;
            end
        end
    end

    neuron_mul #(
        .dataWidth(dataWidth)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (xfer),
        .a      (bus.in_data),
        .b      (bus.weight),
        .prod_p1(prod_p1),
        .vld_p1 (vld_p1)
    );

    // stage 2: accumulator, seeded with the sign-extended bias on start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
        end else if (load) begin
            acc_p2 <= ACCW'(bus.bias);
        end else if (vld_p1) begin
            acc_p2 <= acc_nxt;
        end
    end

`ifdef NEURON_MAC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (load) begin
            sat_flag <= 1'b0;
        end else if (vld_p1 && ovf) begin
            sat_flag <= 1'b1;
        end
    end
`endif

    // stage 3: result register, captured once the drained sum has settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_p3 <= 1'b0;
            out_sum_p3 <= '0;
        end else if (state_q == OUT) begin
            if (!out_vld_p3) begin
                out_vld_p3 <= 1'b1;
                out_sum_p3 <= acc_p2;
            end else if (bus.out_ready) begin
                out_vld_p3 <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_vld_p3;
    assign bus.out_sum   = out_sum_p3;

endmodule
